// File: rtl/bnn_sched_pkg.sv
// Shared types and constants for the BNN inference scheduler:
// FSM state encoding and the default image/result geometry.
package bnn_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } sched_state_e;

  localparam int DEF_IMG_BITS = 900;
  localparam int DEF_RES_W    = 4;

  // Result code reported to the consumer when the watchdog expires.
  localparam logic [DEF_RES_W-1:0] RES_TIMEOUT = '1;

endpackage

// File: rtl/bnn_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at rr_ptr and wraps,
// producing a one-hot grant plus the binary index of the winner.
module bnn_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a latch behind.
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bnn_infer_scheduler.sv
// Round-robin sequencer in front of the single BNN core: grants one image
// source, runs the core under a watchdog and holds the result until acked.
module bnn_infer_scheduler
  import bnn_sched_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int IMG_BITS       = DEF_IMG_BITS,
  parameter int RES_W          = DEF_RES_W,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*IMG_BITS-1:0] img_flat,
  input  logic                        result_ack,
  output logic [IMG_BITS-1:0]         core_img,
  output logic                        core_start,
  input  logic                        core_done,
  input  logic [RES_W-1:0]            core_result,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        busy,
  output logic [RES_W-1:0]            result_out,
  output logic                        result_valid,
  output logic                        result_owner,
  output logic                        timeout_err,
  output logic [CNT_W-1:0]            infer_cnt,
  output logic [7:0]                  timeout_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  sched_state_e         state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     owner_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IMG_BITS-1:0]  core_img_q;
  logic                 core_start_q;
  logic [WD_W-1:0]      wd_q;
  logic [RES_W-1:0]     result_out_q;
  logic                 result_valid_q;
  logic                 timeout_err_q;
  logic [CNT_W-1:0]     infer_cnt_q;
  logic [7:0]           timeout_cnt_q;

  logic [NUM_REQ-1:0]   win_gnt_d;
  logic [IDX_W-1:0]     win_idx_d;
  logic                 win_any_d;
  logic [IDX_W-1:0]     next_ptr_d;
  logic [IMG_BITS-1:0]  img_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_img
    assign img_arr[g] = img_flat[g*IMG_BITS +: IMG_BITS];
  end

  bnn_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (win_gnt_d),
    .idx    (win_idx_d),
    .any    (win_any_d)
  );

  assign next_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // NOTE: all state below uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      grant_q        <= '0;
      // NOTE: the wide image register is cleared on reset on purpose; the core must never see stale data.
      core_img_q     <= '0;
      core_start_q   <= 1'b0;
      wd_q           <= '0;
      result_out_q   <= '0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      infer_cnt_q    <= '0;
      timeout_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (win_any_d) begin
            grant_q    <= win_gnt_d;
            owner_q    <= win_idx_d;
            core_img_q <= img_arr[win_idx_d];
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          core_start_q <= 1'b1;
          wd_q         <= '0;
          state_q      <= ST_RUN;
        end
        ST_RUN: begin
          // A done on the expiry cycle still counts as a real result.
          if (core_done) begin
            result_out_q   <= core_result;
            timeout_err_q  <= 1'b0;
            if (infer_cnt_q != '1) infer_cnt_q <= infer_cnt_q + 1'b1;
            core_start_q   <= 1'b0;
            result_valid_q <= 1'b1;
            state_q        <= ST_HOLD;
          end else if (wd_q == WD_LAST) begin
            result_out_q   <= {RES_W{RES_TIMEOUT[0]}};
            timeout_err_q  <= 1'b1;
            if (timeout_cnt_q != 8'hFF) timeout_cnt_q <= timeout_cnt_q + 1'b1;
            core_start_q   <= 1'b0;
            result_valid_q <= 1'b1;
            state_q        <= ST_HOLD;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (result_ack) begin
            result_valid_q <= 1'b0;
            grant_q        <= '0;
            rr_ptr_q       <= next_ptr_d;
            state_q        <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign core_img     = core_img_q;
  assign core_start   = core_start_q;
  assign grant        = grant_q;
  assign busy         = (state_q != ST_IDLE);
  assign result_out   = result_out_q;
  assign result_valid = result_valid_q;
  assign result_owner = owner_q[0];
  assign timeout_err  = timeout_err_q;
  assign infer_cnt    = infer_cnt_q;
  assign timeout_cnt  = timeout_cnt_q;

endmodule

// File: tb/tb_bnn_infer_scheduler.sv
// Directed-plus-random bench for bnn_infer_scheduler; expectations come from
// a transaction-level model of arbitration order, run length and counters.
module tb_bnn_infer_scheduler;

  localparam int NR = 2;
  localparam int IB = 900;
  localparam int RW = 4;
  localparam int TO = 32;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*IB-1:0]  img_flat;
  logic              result_ack;
  logic [IB-1:0]     core_img;
  logic              core_start;
  logic              core_done;
  logic [RW-1:0]     core_result;
  logic [NR-1:0]     grant;
  logic              busy;
  logic [RW-1:0]     result_out;
  logic              result_valid;
  logic              result_owner;
  logic              timeout_err;
  logic [CW-1:0]     infer_cnt;
  logic [7:0]        timeout_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_ptr  = 0;
  int exp_infer = 0;
  int exp_tcnt  = 0;

  bnn_infer_scheduler #(
    .NUM_REQ        (NR),
    .IMG_BITS       (IB),
    .RES_W          (RW),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .img_flat     (img_flat),
    .result_ack   (result_ack),
    .core_img     (core_img),
    .core_start   (core_start),
    .core_done    (core_done),
    .core_result  (core_result),
    .grant        (grant),
    .busy         (busy),
    .result_out   (result_out),
    .result_valid (result_valid),
    .result_owner (result_owner),
    .timeout_err  (timeout_err),
    .infer_cnt    (infer_cnt),
    .timeout_cnt  (timeout_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_img(input string tag, input logic [IB-1:0] obs, input logic [IB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed[63:0]=%0h expected[63:0]=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic int model_winner(input logic [NR-1:0] r, input int ptr);
    for (int k = 0; k < NR; k++)
      if (r[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  task automatic rand_imgs();
    for (int k = 0; k < NR*IB; k++) img_flat[k] = 1'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, core_start, 0);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_res"}, result_out, 0);
    check({tag, "_terr"}, timeout_err, 0);
    check({tag, "_icnt"}, infer_cnt, 0);
    check({tag, "_tcnt"}, timeout_cnt, 0);
    check({tag, "_owner"}, result_owner, 0);
    check_img({tag, "_img"}, core_img, '0);
  endtask

  // One full grant/run/hold/ack transaction. done_after: RUN cycle on which
  // the core reports done (0 or > TO means it never does).
  task automatic run_txn(input int done_after, input logic [RW-1:0] res,
                         input bit drop_req, input bit stray_ack, input int hold_wait);
    int w;
    int n;
    bit to;
    logic [IB-1:0] exp_img;
    w = model_winner(req, exp_ptr);
    exp_img = img_flat[w*IB +: IB];
    tick();
    check("load_grant", grant, 64'(1 << w));
    check("load_busy", busy, 1);
    check("load_start", core_start, 0);
    check_img("load_img", core_img, exp_img);
    if (drop_req) req[w] = 1'b0;
    rand_imgs();
    tick();
    check("run_start", core_start, 1);
    n = 0;
    while (core_start === 1'b1 && n < TO + 4) begin
      n++;
      core_result = RW'($urandom);
      core_done   = (n == done_after);
      if (n == done_after) core_result = res;
      result_ack  = stray_ack && (n == 2);
      tick();
      core_done  = 1'b0;
      result_ack = 1'b0;
    end
    to = !(done_after >= 1 && done_after <= TO);
    check("run_cycles", n, to ? TO : done_after);
    if (to) exp_tcnt = (exp_tcnt == 255) ? 255 : exp_tcnt + 1;
    else    exp_infer = (exp_infer == 65535) ? 65535 : exp_infer + 1;
    check("hold_valid", result_valid, 1);
    check("hold_res", result_out, to ? 4'hF : res);
    check("hold_terr", timeout_err, to);
    check("hold_owner", result_owner, w);
    check("hold_icnt", infer_cnt, exp_infer);
    check("hold_tcnt", timeout_cnt, exp_tcnt);
    check("hold_grant", grant, 64'(1 << w));
    check_img("hold_img", core_img, exp_img);
    repeat (hold_wait) tick();
    check("hold_stable", result_valid, 1);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check("ack_grant", grant, 0);
    check("ack_valid", result_valid, 0);
    check("ack_busy", busy, 0);
    exp_ptr = (w + 1) % NR;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    result_ack = 1'b0;
    core_done = 1'b0;
    core_result = '0;
    rand_imgs();
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Stray done/ack while idle must do nothing.
    core_done = 1'b1;
    core_result = 4'd5;
    result_ack = 1'b1;
    tick();
    core_done = 1'b0;
    result_ack = 1'b0;
    tick();
    check("stray_busy", busy, 0);
    check("stray_valid", result_valid, 0);
    check("stray_icnt", infer_cnt, 0);
    check("stray_grant", grant, 0);

    // Single request with an alternating 1010... image.
    for (int k = 0; k < IB; k++) img_flat[k] = ((IB - 1 - k) % 2) == 0;
    req = 2'b01;
    run_txn(20, 4'd7, 1'b1, 1'b0, 0);

    // Both requesting continuously: grants must alternate.
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      rand_imgs();
      run_txn(int'($urandom_range(1, TO)), RW'($urandom), 1'b0, 1'b0, 0);
    end
    req = 2'b00;
    tick();

    // Watchdog expiry, with a stray ack during RUN.
    rand_imgs();
    req = 2'b01;
    run_txn(0, 4'd0, 1'b1, 1'b1, int'($urandom_range(0, 3)));

    // Done on the very expiry cycle wins.
    rand_imgs();
    req = 2'b10;
    run_txn(TO, 4'd3, 1'b1, 1'b0, 1);

    rand_imgs();
    req = 2'b01;
    run_txn(int'($urandom_range(1, TO)), RW'($urandom), 1'b1, 1'b0, 0);

    // Reset on RUN cycle 5.
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    repeat (4) tick();
    check("pre_rst_start", core_start, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("mid_rst");
    exp_ptr = 0;
    exp_infer = 0;
    exp_tcnt = 0;

    rand_imgs();
    req = 2'b11;
    run_txn(int'($urandom_range(1, TO)), RW'($urandom), 1'b1, 1'b0, 0);
    req = 2'b00;
    tick();

    rand_imgs();
    req = 2'b10;
    run_txn(int'($urandom_range(1, TO)), RW'($urandom), 1'b1, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
